key_led_pattern_ctrl: RTL and testbench

Parametrised LED pattern controller driven by push-buttons, and the successor to the single-purpose key/LED latch blocks. Each of 4 keys is synchronised, debounced and edge-detected. The press selects one of 4 latched display modes, and pressing the active mode's key again returns to IDLE. A shared step timer advances an N_LED-wide pattern (flow left, flow right, blink, marquee) once per TICK_CYCLES clocks. The block sits between the board key pins and the LED pins.

---
 rtl/key_led_pkg.sv | 40 ++++
 rtl/key_led_pattern_ctrl_key_debounce.sv | 67 ++++++
 rtl/key_led_pattern_ctrl.sv | 114 +++++++++++
 tb/tb_key_led_pattern_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared types and helpers for the key-driven LED pattern controller.
package key_led_pkg;

  localparam int unsigned N_KEYS = 4;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_FLOW_L  = 3'd1,
    MODE_FLOW_R  = 3'd2,
    MODE_BLINK   = 3'd3,
    MODE_MARQUEE = 3'd4
  } mode_t;

  // Key index to the display mode it selects.
  function automatic mode_t mode_of(input logic [1:0] k);
    mode_t m;
    case (k)
      2'd0:    m = MODE_FLOW_L;
      2'd1:    m = MODE_FLOW_R;
      2'd2:    m = MODE_BLINK;
      default: m = MODE_MARQUEE;
    endcase
    return m;
  endfunction

  // One bit of the pattern loaded on entry to a mode, for an n_led-wide bar.
  function automatic logic init_led_bit(input mode_t m, input int unsigned idx,
                                        input int unsigned n_led);
    logic b;
    case (m)
      MODE_FLOW_L:  b = (idx == 0);
      MODE_FLOW_R:  b = (idx == n_led - 1);
      MODE_BLINK:   b = 1'b1;
      MODE_MARQUEE: b = ((idx % 2) == 0);
      default:      b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/key_led_pattern_ctrl_key_debounce.sv
// Per-key synchroniser, debouncer and press-edge detector.
// A key that is already held when reset releases must be seen released
// before it can produce a press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam int unsigned CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic        RELEASED_RAW = KEY_ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          synced;
  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic          level_d;

  // Two-flop synchroniser; vld_q marks when sync_q[1] holds a real pin sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RELEASED_RAW}};
      vld_q  <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_raw};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign synced = KEY_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      key_level <= 1'b0;
    end else if (synced == key_level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      key_level <= synced;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Press pulse on an accepted rise, suppressed until the key has been seen released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      armed_q <= armed_q | (vld_q[1] & ~synced);
      level_d <= key_level;
      press   <= armed_q & key_level & ~level_d;
    end
  end

endmodule

// File: rtl/key_led_pattern_ctrl.sv
// Push-button LED pattern controller: four debounced keys select one of
// four latched display modes; a shared step timer advances the pattern.
//
// mode         | meaning
// -------------+-----------------------------------------------
// MODE_IDLE    | LEDs dark, step timer held at zero
// MODE_FLOW_L  | single lit LED rotating towards the MSB
// MODE_FLOW_R  | single lit LED rotating towards bit 0
// MODE_BLINK   | all LEDs toggling together
// MODE_MARQUEE | alternating LEDs swapping each step
module key_led_pattern_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned N_LED           = 4,
  parameter int unsigned TICK_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key,
  output logic [N_LED-1:0] led,
  output logic [2:0]       mode,
  output logic             step
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [N_KEYS-1:0] press;

  mode_t             mode_q, mode_d, sel_mode;
  logic              sel_valid;
  logic [1:0]        sel_key;
  logic [N_LED-1:0]  led_q, led_d, init_pat;
  logic [TW-1:0]     tick_q, tick_d;
  logic              step_q, step_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw   (key[i]),
      .key_level (),
      .press     (press[i])
    );
  end

  // State register: mode, pattern, step timer and step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_IDLE;
      led_q  <= '0;
      tick_q <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      step_q <= step_d;
    end
  end

  // Next mode: lowest-index press wins; pressing the active mode's key exits to idle.
  always_comb begin
    sel_valid = 1'b0;
    sel_key   = 2'd0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (press[k]) begin
        sel_valid = 1'b1;
        sel_key   = 2'(k);
      end
    end
    sel_mode = mode_of(sel_key);
    mode_d   = mode_q;
    if (sel_valid) begin
      mode_d = (mode_q == sel_mode) ? MODE_IDLE : sel_mode;
    end
  end

  // Pattern, timer and step: a mode change reloads and restarts, otherwise advance on terminal count.
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      init_pat[i] = init_led_bit(sel_mode, i, N_LED);
    end
    led_d  = led_q;
    tick_d = tick_q;
    if (sel_valid) begin
      tick_d = '0;
      led_d  = (mode_d == MODE_IDLE) ? '0 : init_pat;
    end else if (mode_q == MODE_IDLE) begin
      tick_d = '0;
      led_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      case (mode_q)
        MODE_FLOW_L: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
        MODE_FLOW_R: led_d = {led_q[0], led_q[N_LED-1:1]};
        default:     led_d = ~led_q;
      endcase
    end else begin
      tick_d = tick_q + TW'(1);
    end
    step_d = (mode_d != MODE_IDLE) && (tick_d == TICK_LAST);
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign step = step_q;

endmodule

// File: tb/tb_key_led_pattern_ctrl.sv
// Randomised and directed bench for key_led_pattern_ctrl with a reference
// model that works from elapsed time per mode rather than register state.
module tb_key_led_pattern_ctrl;

  localparam int N_LED = 4;
  localparam int TICK  = 4;
  localparam int DEB   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       key = 4'hF;
  logic [N_LED-1:0] led;
  logic [2:0]       mode;
  logic             step;

  int vectors = 0;
  int miscompares = 0;

  key_led_pattern_ctrl #(
    .N_LED(N_LED), .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .led(led), .mode(mode), .step(step)
  );

  always #5 clk = ~clk;

  // model state
  logic [63:0] m_hist [4];
  bit          m_acc [4];
  bit          m_seen_rel [4];
  int          m_nsamp;
  bit [3:0]    m_rise_q1, m_rise_q2;
  int          m_mode;
  int          m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_LED-1:0] exp_led(input int md, input int age);
    int s;
    logic [N_LED-1:0] alt;
    s = age / TICK;
    alt = '0;
    for (int i = 0; i < N_LED; i += 2) alt[i] = 1'b1;
    case (md)
      1: return N_LED'(1) << (s % N_LED);
      2: return N_LED'(1 << (N_LED - 1)) >> (s % N_LED);
      3: return (s % 2 == 1) ? '0 : '1;
      4: return (s % 2 == 1) ? ~alt : alt;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_hist[k] = '0;
      m_acc[k] = 1'b0;
      m_seen_rel[k] = 1'b0;
    end
    m_nsamp = 0;
    m_rise_q1 = '0;
    m_rise_q2 = '0;
    m_mode = 0;
    m_age = 0;
  endtask

  // One rising edge of the model; key is the level sampled at that edge.
  task automatic model_edge();
    bit [3:0] pressed;
    bit [3:0] rise;
    bit all_diff;
    int sel;
    pressed = ~key;
    rise = '0;
    m_nsamp++;
    for (int k = 0; k < 4; k++) begin
      m_hist[k] = {m_hist[k][62:0], pressed[k]};
      if (m_nsamp >= 3 && !m_hist[k][2]) m_seen_rel[k] = 1'b1;
      all_diff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (m_hist[k][j] == m_acc[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_acc[k] = !m_acc[k];
        if (m_acc[k] && m_seen_rel[k]) rise[k] = 1'b1;
      end
    end
    if (m_rise_q2 != 0) begin
      sel = 3;
      for (int k = 3; k >= 0; k--) if (m_rise_q2[k]) sel = k;
      m_mode = (m_mode == sel + 1) ? 0 : sel + 1;
      m_age = 0;
    end else if (m_mode != 0) begin
      m_age++;
    end
    m_rise_q2 = m_rise_q1;
    m_rise_q1 = rise;
  endtask

  task automatic compare();
    chk("led", 32'(led), 32'(exp_led(m_mode, m_age)));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("step", 32'(step), 32'((m_mode != 0) && (m_age % TICK == TICK - 1)));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  // Assert reset between edges, check the asynchronous clear, release on a negedge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    key = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    cycles(20);

    // FLOW_L entry latency and a full wrap
    key = 4'b1110;
    cycles(6);
    chk("flow_l_early", 32'(mode), 32'd0);
    cycles(1);
    chk("flow_l_mode", 32'(mode), 32'd1);
    chk("flow_l_led", 32'(led), 32'h1);
    cycles(4);
    key = 4'hF;
    cycles(20);

    // 2-cycle glitch on key[1] is rejected
    key = 4'b1101;
    cycles(2);
    key = 4'hF;
    cycles(10);
    chk("glitch_mode", 32'(mode), 32'd1);

    // FLOW_R, then toggle off with a second press
    key = 4'b1101;
    cycles(10);
    chk("flow_r_mode", 32'(mode), 32'd2);
    key = 4'hF;
    cycles(20);
    key = 4'b1101;
    cycles(8);
    chk("toggle_off", 32'(mode), 32'd0);
    key = 4'hF;
    cycles(10);

    // BLINK then MARQUEE mid-blink
    key = 4'b1011;
    cycles(14);
    key = 4'hF;
    cycles(3);
    key = 4'b0111;
    cycles(8);
    chk("marquee_mode", 32'(mode), 32'd4);
    cycles(6);
    key = 4'hF;
    cycles(8);

    // simultaneous key[3]+key[0]: lowest index wins, release of key[3] is silent
    key = 4'b0110;
    cycles(8);
    chk("simul_mode", 32'(mode), 32'd1);
    key = 4'b1110;
    cycles(8);
    chk("simul_hold", 32'(mode), 32'd1);
    key = 4'hF;
    cycles(8);

    // reset during MARQUEE with key[2] held through it
    key = 4'b0111;
    cycles(8);
    key = 4'hF;
    cycles(6);
    chk("pre_rst_mode", 32'(mode), 32'd4);
    key = 4'b1011;
    cycles(2);
    pulse_reset();
    cycles(15);
    chk("held_key_mode", 32'(mode), 32'd0);
    key = 4'hF;
    cycles(8);
    key = 4'b1011;
    cycles(8);
    chk("repress_mode", 32'(mode), 32'd3);
    key = 4'hF;
    cycles(6);

    // random key activity with occasional reset
    for (int it = 0; it < 1200; it++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) key[k] = ~key[k];
      if ($urandom_range(0, 199) == 0) pulse_reset();
      cycles($urandom_range(1, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
